// File: rtl/hex_bcd_pkg.sv
// Shared types and constants for the hex_bcd_writer block:
// FSM states, seven-segment glyphs and conversion limits.
package hex_bcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        ENCODE,
        WRITE
    } state_t;

    // Active-low glyphs, bit order {dp,g,f,e,d,c,b,a}
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hBF;

    localparam int MAX_DISPLAY = 9999;
    localparam int CONV_ITERS  = 14;

    // Double-dabble correction for one BCD nibble
    function automatic logic [3:0] dabble_adj(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

endpackage

// File: rtl/hex_bcd_writer_if.sv
// Value handshake plus Avalon-MM write bus of the HEX writer.
// master = value producer / bus observer, slave = the writer block.
interface hex_bcd_writer_if;

    logic [15:0] value_in;
    logic        value_valid;
    logic        value_ready;
    logic [1:0]  avm_address;
    logic        avm_chipselect;
    logic        avm_write_n;
    logic [31:0] avm_writedata;

    modport master (
        output value_in,
        output value_valid,
        input  value_ready,
        input  avm_address,
        input  avm_chipselect,
        input  avm_write_n,
        input  avm_writedata
    );

    modport slave (
        input  value_in,
        input  value_valid,
        output value_ready,
        output avm_address,
        output avm_chipselect,
        output avm_write_n,
        output avm_writedata
    );

endinterface

// File: rtl/hex_bcd_writer_seg7_encode.sv
// One BCD digit to a seven-segment byte, with blank/dash
// overrides and selectable segment polarity.
module seg7_encode #(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic [3:0] digit,
    input  logic       blank,
    input  logic       dash,
    output logic [7:0] seg
);
    import hex_bcd_pkg::*;

    logic [7:0] glyph;
    logic [7:0] raw;

    // Digit lookup; codes above 9 never occur and show blank
    always_comb begin
        glyph = SEG_BLANK;
        case (digit)
            4'd0:    glyph = SEG_0;
            4'd1:    glyph = SEG_1;
            4'd2:    glyph = SEG_2;
            4'd3:    glyph = SEG_3;
            4'd4:    glyph = SEG_4;
            4'd5:    glyph = SEG_5;
            4'd6:    glyph = SEG_6;
            4'd7:    glyph = SEG_7;
            4'd8:    glyph = SEG_8;
            4'd9:    glyph = SEG_9;
            default: glyph = SEG_BLANK;
        endcase
    end

    // Dash wins over blank, blank wins over the digit glyph
    always_comb begin
        raw = glyph;
        if (dash)
            raw = SEG_DASH;
        else if (blank)
            raw = SEG_BLANK;
    end

    assign seg = ACTIVE_LOW ? raw : ~raw;

endmodule

// File: rtl/hex_bcd_writer.sv
// Binary value -> BCD (double-dabble) -> seven-segment word,
// written once to the HEX3..HEX0 PIO over Avalon-MM.
module hex_bcd_writer #(
    parameter bit         ACTIVE_LOW    = 1'b1,
    parameter bit         BLANK_LEADING = 1'b1,
    parameter logic [1:0] PIO_ADDR      = 2'd0
) (
    input  logic             clk,
    input  logic             reset,
    hex_bcd_writer_if.slave  bus,
    output logic             busy,
    output logic             overflow
);
    import hex_bcd_pkg::*;

    state_t      state;
    state_t      next_state;
    logic        accept;
    logic        too_big;
    logic [13:0] bin;
    logic [15:0] bcd;
    logic [15:0] bcd_adj;
    logic [3:0]  iter;
    logic [3:0]  blank;
    logic [31:0] seg_word;

    assign accept  = bus.value_valid && bus.value_ready;
    assign too_big = bus.value_in > 16'(MAX_DISPLAY);

    // State register
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE:
                if (accept)
                    next_state = too_big ? ENCODE : CONV;
            CONV:
                if (iter == 4'(CONV_ITERS - 1))
                    next_state = ENCODE;
            ENCODE:
                next_state = WRITE;
            WRITE:
                next_state = IDLE;
            default:
                next_state = IDLE;
        endcase
    end

    // Bus outputs; the strobe is masked while reset is held
    always_comb begin
        bus.value_ready    = (state == IDLE) && !reset;
        bus.avm_address    = PIO_ADDR;
        bus.avm_chipselect = (state == WRITE) && !reset;
        bus.avm_write_n    = !((state == WRITE) && !reset);
        busy               = (state != IDLE);
    end

    // Per-nibble add-3 correction ahead of each shift
    always_comb begin
        bcd_adj = '0;
        for (int i = 0; i < 4; i++)
            bcd_adj[4*i +: 4] = dabble_adj(bcd[4*i +: 4]);
    end

    // Leading-zero blanking; the units digit is always shown
    always_comb begin
        blank    = '0;
        blank[3] = BLANK_LEADING && (bcd[15:12] == 4'd0);
        blank[2] = blank[3] && (bcd[11:8] == 4'd0);
        blank[1] = blank[2] && (bcd[7:4] == 4'd0);
    end

    for (genvar g = 0; g < 4; g++) begin : g_seg
        seg7_encode #(
            .ACTIVE_LOW (ACTIVE_LOW)
        ) u_seg (
            .digit (bcd[4*g +: 4]),
            .blank (blank[g]),
            .dash  (overflow),
            .seg   (seg_word[8*g +: 8])
        );
    end

    // Datapath: latch value, run conversion, register the word
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow          <= 1'b0;
            bin               <= '0;
            bcd               <= '0;
            iter              <= '0;
            bus.avm_writedata <= '0;
        end else begin
            case (state)
                IDLE:
                    if (accept) begin
                        overflow <= too_big;
                        if (!too_big) begin
                            bin  <= bus.value_in[13:0];
                            bcd  <= '0;
                            iter <= '0;
                        end
                    end
                CONV: begin
                    {bcd, bin} <= {bcd_adj[14:0], bin, 1'b0};
                    iter       <= iter + 4'd1;
                end
                ENCODE:
                    bus.avm_writedata <= seg_word;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hex_bcd_writer.sv
// Self-checking bench: three writer variants driven in parallel,
// compared against a decimal/arithmetic display model.
module tb_hex_bcd_writer;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] value_in;
    logic        value_valid;
    logic        busy_a, busy_b, busy_c;
    logic        ovf_a, ovf_b, ovf_c;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    localparam logic [7:0] SEG_TAB [10] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
        8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
    };

    hex_bcd_writer_if bus_a ();
    hex_bcd_writer_if bus_b ();
    hex_bcd_writer_if bus_c ();

    assign bus_a.value_in    = value_in;
    assign bus_a.value_valid = value_valid;
    assign bus_b.value_in    = value_in;
    assign bus_b.value_valid = value_valid;
    assign bus_c.value_in    = value_in;
    assign bus_c.value_valid = value_valid;

    hex_bcd_writer u_a (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus_a),
        .busy     (busy_a),
        .overflow (ovf_a)
    );

    hex_bcd_writer #(
        .BLANK_LEADING (1'b0)
    ) u_b (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus_b),
        .busy     (busy_b),
        .overflow (ovf_b)
    );

    hex_bcd_writer #(
        .ACTIVE_LOW (1'b0)
    ) u_c (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus_c),
        .busy     (busy_c),
        .overflow (ovf_c)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [31:0] da;
        logic [31:0] db;
        logic [31:0] dc;
        logic [1:0]  addr;
        logic        wn;
    } wr_t;

    wr_t wq[$];
    wr_t mon_w;

    // Log every cycle in which any variant drives a bus strobe
    always @(negedge clk) begin
        if (bus_a.avm_chipselect || !bus_a.avm_write_n ||
            bus_b.avm_chipselect || !bus_b.avm_write_n ||
            bus_c.avm_chipselect || !bus_c.avm_write_n) begin
            mon_w.cyc  = cyc;
            mon_w.da   = bus_a.avm_writedata;
            mon_w.db   = bus_b.avm_writedata;
            mon_w.dc   = bus_c.avm_writedata;
            mon_w.addr = bus_a.avm_address;
            mon_w.wn   = bus_a.avm_write_n;
            wq.push_back(mon_w);
        end
    end

    function automatic logic [31:0] model(input int v, input bit al,
                                          input bit bl);
        logic [31:0] w;
        logic [7:0]  b;
        int          p;
        w = '0;
        p = 1;
        for (int i = 0; i < 4; i++) begin
            if (v > 9999)
                b = 8'hBF;
            else if (bl && i > 0 && v < p)
                b = 8'hFF;
            else
                b = SEG_TAB[(v / p) % 10];
            w[8*i +: 8] = al ? b : ~b;
            p = p * 10;
        end
        return w;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic xact(input logic [15:0] v);
        int   e;
        int   lat;
        logic ov;
        ov  = (v > 16'd9999);
        lat = ov ? 2 : 16;
        @(negedge clk);
        chk("idle_ready", 32'(bus_a.value_ready), 1);
        wq.delete();
        value_in    = v;
        value_valid = 1'b1;
        @(posedge clk);
        #1;
        value_valid = 1'b0;
        e = cyc;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1)
                chk("ready_low", 32'(bus_a.value_ready), 0);
            if (c == lat - 1)
                chk("busy", {29'd0, busy_a, busy_b, busy_c}, 7);
            if (c == lat + 1)
                chk("ready_back", 32'(bus_a.value_ready), 1);
        end
        chk("n_writes", wq.size(), 1);
        if (wq.size() > 0) begin
            chk("wr_cycle", wq[0].cyc - e + 1, lat);
            chk("data_a", wq[0].da, model(int'(v), 1'b1, 1'b1));
            chk("data_b", wq[0].db, model(int'(v), 1'b1, 1'b0));
            chk("data_c", wq[0].dc, model(int'(v), 1'b0, 1'b1));
            chk("addr", 32'(wq[0].addr), 0);
            chk("write_n", 32'(wq[0].wn), 0);
        end
        chk("ovf", {29'd0, ovf_a, ovf_b, ovf_c}, ov ? 7 : 0);
        chk("hold_a", bus_a.avm_writedata, model(int'(v), 1'b1, 1'b1));
    endtask

    initial begin
        int e;
        logic [15:0] v;
        reset       = 1'b1;
        value_in    = '0;
        value_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(bus_a.value_ready), 0);
        chk("rst_wdata", bus_a.avm_writedata, 0);
        chk("rst_cs", 32'(bus_a.avm_chipselect), 0);
        chk("rst_wn", 32'(bus_a.avm_write_n), 1);
        chk("rst_addr", 32'(bus_a.avm_address), 0);
        chk("rst_ovf", 32'(ovf_a), 0);
        chk("rst_busy", 32'(busy_a), 0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 32'(bus_a.value_ready), 1);

        xact(16'd1234);
        xact(16'd7);
        xact(16'd0);
        xact(16'd9999);
        xact(16'd10000);
        xact(16'd65535);
        xact(16'd42);
        xact(16'd8);

        // Reset in the middle of converting 5555
        @(negedge clk);
        wq.delete();
        value_in    = 16'd5555;
        value_valid = 1'b1;
        @(posedge clk);
        #1;
        value_valid = 1'b0;
        repeat (8) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_ready", 32'(bus_a.value_ready), 0);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        chk("mid_rst_nowr", wq.size(), 0);
        chk("mid_rst_wdata", bus_a.avm_writedata, 0);
        chk("mid_rst_ready1", 32'(bus_a.value_ready), 1);
        chk("mid_rst_busy", 32'(busy_a), 0);

        // Back-to-back with valid held: 1111 then 2222
        @(negedge clk);
        wq.delete();
        value_in    = 16'd1111;
        value_valid = 1'b1;
        @(posedge clk);
        #1;
        e = cyc;
        value_in = 16'd2222;
        for (int c = 1; c <= 17; c++) @(negedge clk);
        chk("b2b_ready17", 32'(bus_a.value_ready), 1);
        @(posedge clk);
        #1;
        value_valid = 1'b0;
        repeat (24) @(negedge clk);
        chk("b2b_n", wq.size(), 2);
        if (wq.size() == 2) begin
            chk("b2b_c0", wq[0].cyc - e + 1, 16);
            chk("b2b_c1", wq[1].cyc - e + 1, 33);
            chk("b2b_d0", wq[0].da, 32'hF9F9F9F9);
            chk("b2b_d1", wq[1].da, 32'hA4A4A4A4);
        end

        for (int i = 0; i < 16; i++) begin
            if ($urandom_range(0, 3) == 0)
                v = 16'($urandom_range(10000, 65535));
            else
                v = 16'($urandom_range(0, 9999));
            xact(v);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
